instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface in the multicycle CPU.
- Owns the PC and the instruction register (IR). On request from the control unit it drives byte address and InsMemRW to the instruction memory, then captures the 32-bit big-endian word into IR and advances PC by 4.
- Applies PC redirects (branch, jump, register jump) between fetches.
- Flags misaligned or out-of-range fetch addresses without touching memory.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_next_calc.sv | 25 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path.
package cpu_pkg;

    // PCSrc redirect encodings
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    // Default PC value after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction fetch FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StDone  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for branch, jump and register-jump redirects.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_src_i,
    input  logic [31:0] branch_offset_i,
    input  logic [25:0] jump_target_i,
    input  logic [31:0] rs_value_i,
    output logic [31:0] pc_next_o
);

    // Select redirect target; branch offset is in words, pc already past the branch
    always_comb begin
        pc_next_o = pc_i;
        unique case (pc_src_i)
            PC_HOLD:   pc_next_o = pc_i;
            PC_BRANCH: pc_next_o = pc_i + (branch_offset_i << 2);
            PC_JUMP:   pc_next_o = {pc_i[31:28], jump_target_i, 2'b00};
            PC_JR:     pc_next_o = rs_value_i;
            default:   pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, issues single-word reads to instruction memory.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic        pc_update,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] rs_value,
    output logic [31:0] ins_addr,
    output logic        InsMemRW,
    input  logic [31:0] instruction,
    output logic [31:0] IR,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    localparam logic [31:0] LastWordAddr = 32'(MEM_BYTES - 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         rw_q, rw_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [31:0]  pc_redirect;
    logic [31:0]  pc_eff;
    logic         fetch_ok;

    pc_next_calc u_pc_next_calc (
        .pc_i            (pc_q),
        .pc_src_i        (PCSrc),
        .branch_offset_i (branch_offset),
        .jump_target_i   (jump_target),
        .rs_value_i      (rs_value),
        .pc_next_o       (pc_redirect)
    );

    // Redirect is applied before the legality check so a same-edge fetch uses the new pc
    always_comb begin
        pc_eff   = pc_update ? pc_redirect : pc_q;
        fetch_ok = (pc_eff[1:0] == 2'b00) && (pc_eff <= LastWordAddr);
    end

    // Next-state and registered-output logic for the fetch FSM
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rw_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                pc_d = pc_eff;
                if (fetch_req) begin
                    if (fetch_ok) begin
                        state_d = StIssue;
                        rw_d    = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                ir_d    = instruction;
                pc_d    = pc_q + 32'd4;
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset discards any fetch in flight
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ins_addr   = pc_q;
    assign InsMemRW   = rw_q;
    assign IR         = ir_q;
    assign pc         = pc_q;
    assign busy       = busy_q;
    assign fetch_done = done_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a behavioural PC/IR model.
module tb_instr_fetch_unit;

    localparam int unsigned MemBytes = 128;
    localparam logic [31:0] ResetPc  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_update;
    logic [1:0]  pc_src;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] rs_value;
    logic [31:0] ins_addr;
    logic        ins_mem_rw;
    logic [31:0] instruction;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    logic [7:0]  mem [MemBytes];

    int          total;
    int          bad;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    instr_fetch_unit #(
        .RESET_PC  (ResetPc),
        .MEM_BYTES (MemBytes)
    ) dut (
        .CLK           (clk),
        .Reset         (rst_n),
        .fetch_req     (fetch_req),
        .pc_update     (pc_update),
        .PCSrc         (pc_src),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .rs_value      (rs_value),
        .ins_addr      (ins_addr),
        .InsMemRW      (ins_mem_rw),
        .instruction   (instruction),
        .IR            (ir),
        .pc            (pc),
        .busy          (busy),
        .fetch_done    (fetch_done),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int base;
        base = int'(a % MemBytes);
        return {mem[base], mem[(base + 1) % MemBytes], mem[(base + 2) % MemBytes],
                mem[(base + 3) % MemBytes]};
    endfunction

    // Big-endian combinational memory
    always_comb instruction = word_at(ins_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_redirect(input logic [31:0] cur, input logic [1:0] src,
                                                   input logic [31:0] off, input logic [25:0] tgt,
                                                   input logic [31:0] rs);
        case (src)
            2'd1:    return cur + off * 32'd4;
            2'd2:    return (cur & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
            2'd3:    return rs;
            default: return cur;
        endcase
    endfunction

    function automatic bit model_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a + 4 <= MemBytes) && (a <= 32'hFFFF_FFFB);
    endfunction

    task automatic drop_inputs();
        fetch_req     = 1'b0;
        pc_update     = 1'b0;
        pc_src        = 2'd0;
        branch_offset = 32'h0;
        jump_target   = 26'h0;
        rs_value      = 32'h0;
    endtask

    // One IDLE-cycle operation; on an accepted fetch, follows it through ISSUE and DONE
    // while holding the request and a bogus redirect to show they are ignored.
    task automatic idle_op(input bit upd, input logic [1:0] src, input logic [31:0] off,
                           input logic [25:0] tgt, input logic [31:0] rs, input bit req);
        logic [31:0] npc;
        @(negedge clk);
        fetch_req     = req;
        pc_update     = upd;
        pc_src        = src;
        branch_offset = off;
        jump_target   = tgt;
        rs_value      = rs;
        npc = upd ? model_redirect(m_pc, src, off, tgt, rs) : m_pc;
        m_pc = npc;
        @(posedge clk);
        #1;
        if (req && model_legal(npc)) begin
            check_val("issue_rw", 32'(ins_mem_rw), 32'd1);
            check_val("issue_busy", 32'(busy), 32'd1);
            check_val("issue_done_lo", 32'(fetch_done), 32'd0);
            check_val("issue_addr", ins_addr, npc);
            pc_src   = 2'd3;
            rs_value = 32'h0000_0044;
            @(posedge clk);
            #1;
            m_ir = word_at(npc);
            m_pc = npc + 32'd4;
            check_val("done_pulse", 32'(fetch_done), 32'd1);
            check_val("done_rw", 32'(ins_mem_rw), 32'd0);
            check_val("done_ir", ir, m_ir);
            check_val("done_pc", pc, m_pc);
            @(posedge clk);
            #1;
            check_val("idle_busy", 32'(busy), 32'd0);
            check_val("idle_done_lo", 32'(fetch_done), 32'd0);
            check_val("idle_pc", pc, m_pc);
        end else if (req) begin
            check_val("err_pulse", 32'(fetch_err), 32'd1);
            check_val("err_rw", 32'(ins_mem_rw), 32'd0);
            check_val("err_ir", ir, m_ir);
            check_val("err_pc", pc, m_pc);
            check_val("err_busy", 32'(busy), 32'd0);
            drop_inputs();
            @(posedge clk);
            #1;
            check_val("err_clear", 32'(fetch_err), 32'd0);
        end else begin
            check_val("upd_pc", pc, m_pc);
            check_val("upd_busy", 32'(busy), 32'd0);
            check_val("upd_err", 32'(fetch_err), 32'd0);
        end
        @(negedge clk);
        drop_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < int'(MemBytes); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C;
        mem[1] = 8'h01;
        mem[2] = 8'h00;
        mem[3] = 8'h04;
        drop_inputs();
        rst_n = 1'b0;
        m_pc  = ResetPc;
        m_ir  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pc", pc, ResetPc);
        check_val("rst_ir", ir, 32'h0);
        check_val("rst_rw", 32'(ins_mem_rw), 32'd0);
        check_val("rst_done", 32'(fetch_done), 32'd0);
        check_val("rst_err", 32'(fetch_err), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First fetch from address 0
        idle_op(1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b1);
        check_val("first_ir", ir, 32'h8C01_0004);
        check_val("first_pc", pc, 32'h4);

        // Back-to-back with fetch_req held: one accept every 3 cycles
        idle_op(1'b1, 2'd3, 32'h0, 26'h0, 32'h0, 1'b0);
        @(negedge clk);
        fetch_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            check_val("b2b_done", 32'(fetch_done), (c % 3 == 1) ? 32'd1 : 32'd0);
            if (c % 3 == 1) check_val("b2b_ir", ir, word_at(32'(4 * (c / 3))));
        end
        @(negedge clk);
        fetch_req = 1'b0;
        m_pc = 32'd12;
        m_ir = word_at(32'd8);
        check_val("b2b_pc", pc, 32'd12);

        // Branch back to 0 on the same edge as the fetch
        idle_op(1'b1, 2'd3, 32'h0, 26'h0, 32'd8, 1'b0);
        idle_op(1'b1, 2'd1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b1);
        check_val("br_pc", pc, 32'h4);

        // Jump, then misaligned register jump refused
        idle_op(1'b1, 2'd3, 32'h0, 26'h0, 32'd16, 1'b0);
        idle_op(1'b1, 2'd2, 32'h0, 26'h000_0010, 32'h0, 1'b0);
        check_val("jmp_pc", pc, 32'h0000_0040);
        idle_op(1'b1, 2'd3, 32'h0, 26'h0, 32'h6, 1'b1);

        // Last legal word, then past the end
        idle_op(1'b1, 2'd3, 32'h0, 26'h0, 32'd124, 1'b1);
        check_val("edge_pc", pc, 32'd128);
        idle_op(1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b1);

        // Reset during ISSUE discards the fetch
        idle_op(1'b1, 2'd3, 32'h0, 26'h0, 32'd20, 1'b0);
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        #1;
        check_val("pre_rst_rw", 32'(ins_mem_rw), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        fetch_req = 1'b0;
        m_pc = ResetPc;
        m_ir = 32'h0;
        check_val("midrst_pc", pc, ResetPc);
        check_val("midrst_ir", ir, 32'h0);
        check_val("midrst_rw", 32'(ins_mem_rw), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_val("midrst_nodone", 32'(fetch_done), 32'd0);
        end

        // Random redirects and fetches
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  src;
            logic [31:0] off;
            logic [31:0] rs;
            src = 2'($urandom_range(0, 3));
            off = 32'($signed($urandom_range(0, 16)) - 8);
            rs  = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35) * 4);
            idle_op(1'($urandom), src, off, 26'($urandom_range(0, 40)), rs, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
